// File: rtl/if_id_decode_stage.sv
// IF/ID pipeline register with stall/flush, 32-entry register file with
// write-through bypass, and RV32I field/immediate decode.
module if_id_decode_stage #(
   parameter int              XLEN      = 32,
   parameter int              NREG      = 32,
   parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] pc_if,
   input  logic [XLEN-1:0] instr_if,
   input  logic            valid_if,
   input  logic            stall,
   input  logic            flush,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic [XLEN-1:0] pc_id,
   output logic [XLEN-1:0] instr_id,
   output logic            valid_id,
   output logic [6:0]      opcode,
   output logic [4:0]      rd,
   output logic [2:0]      funct3,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [6:0]      funct7,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic [XLEN-1:0] imm
);

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   logic [XLEN-1:0] regs [NREG];

   // Flush wins over stall so a squashed slot never survives a held cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_id    <= '0;
         instr_id <= NOP_INSTR;
         valid_id <= 1'b0;
      end else if (flush) begin
         pc_id    <= pc_if;
         instr_id <= NOP_INSTR;
         valid_id <= 1'b0;
      end else if (!stall) begin
         pc_id    <= pc_if;
         instr_id <= valid_if ? instr_if : NOP_INSTR;
         valid_id <= valid_if;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         regs <= '{default: '0};
      end else if (wb_en && (wb_rd != 5'd0)) begin
         regs[wb_rd] <= wb_data;
      end
   end

   assign opcode = instr_id[6:0];
   assign rd     = instr_id[11:7];
   assign funct3 = instr_id[14:12];
   assign rs1    = instr_id[19:15];
   assign rs2    = instr_id[24:20];
   assign funct7 = instr_id[31:25];

   // The writeback value is forwarded in the same cycle it is being written
   always_comb begin
      rs1_data = '0;
      rs2_data = '0;
      if (rs1 != 5'd0) begin
         rs1_data = (wb_en && (wb_rd == rs1)) ? wb_data : regs[rs1];
      end
      if (rs2 != 5'd0) begin
         rs2_data = (wb_en && (wb_rd == rs2)) ? wb_data : regs[rs2];
      end
   end

   always_comb begin
      imm = '0;
      case (opcode)
         OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:
            imm = {{20{instr_id[31]}}, instr_id[31:20]};
         OP_STORE:
            imm = {{20{instr_id[31]}}, instr_id[31:25], instr_id[11:7]};
         OP_BRANCH:
            imm = {{19{instr_id[31]}}, instr_id[31], instr_id[7],
                   instr_id[30:25], instr_id[11:8], 1'b0};
         OP_LUI, OP_AUIPC:
            imm = {instr_id[31:12], 12'b0};
         OP_JAL:
            imm = {{11{instr_id[31]}}, instr_id[31], instr_id[19:12],
                   instr_id[20], instr_id[30:21], 1'b0};
         default:
            imm = '0;
      endcase
   end

endmodule
